rca_pipe_adder: RTL and testbench
=================================

// Module: rca_pipe_adder
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor with valid/ready flow control.
//  Next generation of the 8-bit RCA datapath: configurable width and pipeline depth,
//  carry-in, carry-out and add/sub mode. Feeds results to BIST compare/response logic
//  at one result per clock. The operand width is split into STAGES carry-chain segments,
//  with a register boundary between segments.
// PARAMETERS
//  WIDTH   8  operand/result width in bits; >= 1
//  STAGES  2  pipeline segments; 1 <= STAGES <= WIDTH; WIDTH % STAGES == 0; SEG = WIDTH/STAGES
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (borrow-in when sub=1, see BEHAVIOUR)
//  sub        in   1      0: a+b+cin; 1: a+~b+~cin, i.e. a-b-cin
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  z          out  WIDTH  sum/difference, aligned across all bits
//  cout       out  1      carry out of MSB; for sub, 1 = no borrow
// BEHAVIOUR
//  - Reset: all stage valid bits, operand skew registers, partial-sum registers, carry
//    registers, out_valid, z, cout (and ovf) go to 0 asynchronously on rst_n low.
//    In-flight transactions are discarded. First output after release is the first
//    operand set accepted after release.
//  - Operand conditioning at accept:
//    - b_eff = b ^ {WIDTH{sub}}
//    - c0 = cin ^ sub
//  - Segment k (0..STAGES-1) adds bits [k*SEG +: SEG] in pipeline stage k, using the
//    carry registered from segment k-1 (c0 for k=0).
//    - Upper operand slices are delayed k cycles (skew).
//    - Finished lower slices are delayed STAGES-1-k cycles (deskew).
//    - z/cout are presented coherently in a single output register.
//  - Latency: exactly STAGES clk edges from accept (in_valid & in_ready) to out_valid,
//    with no stall in between. Throughput: 1 result/cycle while out_ready=1.
//  - Flow control: global stall. adv = ~out_valid | out_ready; in_ready = adv.
//    - On adv, every stage register loads its predecessor.
//    - Stage-0 valid = in_valid & in_ready.
//    - No bubble compaction.
//  - Stall (out_valid=1, out_ready=0): all registers hold; z/cout/out_valid stable;
//    in_ready=0; no loss, no duplication.
//  - in_valid=0 while adv=1 injects a bubble; the bubble's data registers may update,
//    but its valid bit is 0.
//  - Result arithmetic is modulo 2^WIDTH; cout is bit WIDTH of the full sum.
//  - Ordering: results leave in acceptance order.
//  - STAGES=1: single-cycle registered adder, latency 1.
//  - Illegal parameters (WIDTH % STAGES != 0, STAGES > WIDTH, STAGES < 1) cause an
//    elaboration-time error from a generate-guarded $error.
//  - a, b, cin and sub are sampled only on accept; they are don't-care otherwise.
// CONFIGURATION
//  RCA_PIPE_OVF_EN defined: extra output port ovf (out, 1).
//    - ovf = signed two's-complement overflow = carry into MSB ^ carry out of MSB.
//    - Registered and aligned with z; reset 0; held during stall.
//  RCA_PIPE_OVF_EN undefined: no ovf port and no associated logic.
// TESTING  (WIDTH=8, STAGES=2 unless noted)
//  1. a=FF b=01 cin=0 sub=0, out_ready=1
//     -> 2 cycles later: out_valid=1, z=00, cout=1.
//  2. a=05 b=07 cin=0 sub=1
//     -> z=FE, cout=0 (borrow), ovf=0 when RCA_PIPE_OVF_EN.
//  3. 256 back-to-back random a/b/cin/sub, out_ready=1
//     -> one result per cycle, in order, all matching reference model (a±b±cin).
//  4. Fill pipeline, then drop out_ready for 5 cycles
//     -> in_ready=0, z/cout/out_valid held; after release, all results appear once, in order.
//  5. rst_n low mid-stream with 2 transactions in flight
//     -> out_valid=0, z=00 immediately; after release, first result equals first new accept.
//  6. RCA_PIPE_OVF_EN defined: a=7F b=01 add -> z=80, ovf=1.
//     Repeat sweep 3 with WIDTH=16, STAGES=4 and WIDTH=8, STAGES=1 (latencies 4 and 1).

Source files
------------

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder/subtractor: STAGES carry-chain segments with global-stall valid/ready flow.
// Optional macro RCA_PIPE_OVF_EN adds a registered signed-overflow output ovf.
module rca_pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout
`ifdef RCA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam bit PARAMS_OK = (STAGES >= 1) && (STAGES <= WIDTH) &&
                               ((WIDTH % ((STAGES >= 1) ? STAGES : 1)) == 0);
    localparam int SEG = PARAMS_OK ? (WIDTH / STAGES) : WIDTH;

    if (!PARAMS_OK) begin : g_param_check
        $error("rca_pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic             adv;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // One stall signal freezes every stage; bubbles are never squeezed out.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign accept   = in_valid & adv;
    assign b_eff    = b ^ {WIDTH{sub}};
    assign c0       = cin ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        localparam int LO   = k * SEG;
        localparam int REST = WIDTH - LO;
        localparam int DONE = LO + SEG;

        // Operand bits not yet consumed, finished sum bits, and the segment's carry chain.
        logic [REST-1:0] a_rest;
        logic [REST-1:0] b_rest;
        logic            c_in;
        logic            v_in;
        logic [SEG:0]    chain;
        logic [SEG-1:0]  seg_sum;
        logic [DONE-1:0] s_next;
        logic [DONE-1:0] s_q;
        logic            c_q;
        logic            v_q;

        if (k == 0) begin : g_src
            assign a_rest = a;
            assign b_rest = b_eff;
            assign c_in   = c0;
            assign v_in   = accept;
            assign s_next = seg_sum;
        end else begin : g_src
            assign a_rest = gen_stage[k-1].g_skew.a_q;
            assign b_rest = gen_stage[k-1].g_skew.b_q;
            assign c_in   = gen_stage[k-1].c_q;
            assign v_in   = gen_stage[k-1].v_q;
            assign s_next = {seg_sum, gen_stage[k-1].s_q};
        end

        always_comb begin
            // NOTE: every always_comb output gets a default before the loop so no path can infer a latch.
            chain    = '0;
            seg_sum  = '0;
            chain[0] = c_in;
            for (int i = 0; i < SEG; i++) begin
                seg_sum[i]  = a_rest[i] ^ b_rest[i] ^ chain[i];
                chain[i+1]  = (a_rest[i] & b_rest[i]) | (chain[i] & (a_rest[i] ^ b_rest[i]));
            end
        end

        // NOTE: datapath registers are reset too, so z/cout read 0 while the pipe is empty after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                // NOTE: sequential state uses non-blocking assignment so all stages update from pre-edge values.
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (adv) begin
                s_q <= s_next;
                c_q <= chain[SEG];
                v_q <= v_in;
            end
        end

        // Upper operand slices travel alongside until their segment is reached.
        if (k < STAGES - 1) begin : g_skew
            logic [REST-SEG-1:0] a_q;
            logic [REST-SEG-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_rest[REST-1:SEG];
                    b_q <= b_rest[REST-1:SEG];
                end
            end
        end

`ifdef RCA_PIPE_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= chain[SEG] ^ chain[SEG-1];
                end
            end
        end
`endif
    end

    // The last stage register doubles as the coherent output register.
    assign z         = gen_stage[STAGES-1].s_q;
    assign cout      = gen_stage[STAGES-1].c_q;
    assign out_valid = gen_stage[STAGES-1].v_q;

`ifdef RCA_PIPE_OVF_EN
    assign ovf = gen_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Self-checking bench for rca_pipe_adder: directed cases, random sweep, stalls, bubbles and mid-stream reset.
// Reference model tracks each accepted operand set with its arithmetic result and the number of advances it has seen.
module tb_rca_pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             cout;
`ifdef RCA_PIPE_OVF_EN
    logic             ovf;
`endif

    typedef struct {
        logic [WIDTH-1:0] z;
        logic             cout;
        logic             ovf;
        int               age;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    rca_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .cout      (cout)
`ifdef RCA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Integer arithmetic on the operands, independent of any bit-level adder structure.
    function automatic item_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                    input logic icin, input logic isub);
        item_t  it;
        longint span, half, full, sa, sb, sr;
        span = longint'(1) << WIDTH;
        half = span / 2;
        full = isub ? longint'(ia) - longint'(ib) - longint'(icin)
                    : longint'(ia) + longint'(ib) + longint'(icin);
        it.z    = full[WIDTH-1:0];
        it.cout = isub ? (full >= 0) : (full >= span);
        sa = (longint'(ia) >= half) ? longint'(ia) - span : longint'(ia);
        sb = (longint'(ib) >= half) ? longint'(ib) - span : longint'(ib);
        sr = isub ? sa - sb - longint'(icin) : sa + sb + longint'(icin);
        it.ovf = (sr < -half) || (sr >= half);
        it.age = 1;
        return it;
    endfunction

    // One clock: drive at the negedge, check settled outputs, then advance the model on the posedge.
    task automatic cycle(input logic iv, input logic ordy, input logic [WIDTH-1:0] ia,
                         input logic [WIDTH-1:0] ib, input logic icin, input logic isub);
        logic exp_ov;
        logic exp_adv;
        in_valid  = iv;
        out_ready = ordy;
        a         = ia;
        b         = ib;
        cin       = icin;
        sub       = isub;
        #1;
        exp_ov = (q.size() > 0) && (q[0].age >= STAGES);
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check("z", 32'(z), 32'(q[0].z));
            check("cout", 32'(cout), 32'(q[0].cout));
`ifdef RCA_PIPE_OVF_EN
            check("ovf", 32'(ovf), 32'(q[0].ovf));
`endif
        end
        exp_adv = !exp_ov || ordy;
        check("in_ready", 32'(in_ready), 32'(exp_adv));
        @(posedge clk);
        if (exp_adv) begin
            if (exp_ov) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (iv) q.push_back(model(ia, ib, icin, isub));
        end
        @(negedge clk);
    endtask

    task automatic rand_cycle(input logic iv, input logic ordy);
        cycle(iv, ordy, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] exp_fe;
        logic [WIDTH-1:0] max_pos;
        logic [WIDTH-1:0] min_neg;
        ones    = '1;
        exp_fe  = ones - WIDTH'(1);
        max_pos = ones >> 1;
        min_neg = ~max_pos;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_z", 32'(z), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;

        // All-ones plus one wraps to zero with carry out.
        cycle(1'b1, 1'b1, ones, WIDTH'(1), 1'b0, 1'b0);
        repeat (STAGES - 1) cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_z", 32'(z), 32'd0);
        check("t1_cout", 32'(cout), 32'd1);
        cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);

        // 5 - 7 borrows.
        cycle(1'b1, 1'b1, WIDTH'(5), WIDTH'(7), 1'b0, 1'b1);
        repeat (STAGES - 1) cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
        check("t2_z", 32'(z), 32'(exp_fe));
        check("t2_cout", 32'(cout), 32'd0);
`ifdef RCA_PIPE_OVF_EN
        check("t2_ovf", 32'(ovf), 32'd0);
`endif
        cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);

`ifdef RCA_PIPE_OVF_EN
        cycle(1'b1, 1'b1, max_pos, WIDTH'(1), 1'b0, 1'b0);
        repeat (STAGES - 1) cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
        check("t6_z", 32'(z), 32'(min_neg));
        check("t6_ovf", 32'(ovf), 32'd1);
        cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
`endif

        // Back-to-back random sweep.
        repeat (256) rand_cycle(1'b1, 1'b1);

        // Fill, then hold the output for five cycles, then release.
        repeat (STAGES + 1) rand_cycle(1'b1, 1'b1);
        repeat (5) rand_cycle(1'b1, 1'b0);
        repeat (STAGES + 2) rand_cycle(1'b1, 1'b1);

        // Random bubbles and stalls.
        repeat (300) rand_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        repeat (STAGES + 2) rand_cycle(1'b0, 1'b1);

        // Reset with two transactions in flight.
        rand_cycle(1'b1, 1'b1);
        rand_cycle(1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_z", 32'(z), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rand_cycle(1'b1, 1'b1);
        repeat (STAGES + 2) rand_cycle(1'b0, 1'b1);
        repeat (20) rand_cycle(1'b1, 1'b1);
        repeat (STAGES + 2) rand_cycle(1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of run, expected completion within time limit");
        $fatal(1, "timeout");
    end

endmodule
